// File: rtl/alu_share_arb_if.sv
// Request/response/ALU bundle for the shared-ALU arbiter.
// slave is the arbiter side, master is the requester/ALU side.
interface alu_share_arb_if #(
  parameter int DATA_W = 64,
  parameter int OP_W   = 5
);
  logic              flush;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [OP_W-1:0]   req_op0;
  logic [OP_W-1:0]   req_op1;
  logic [DATA_W-1:0] req_src1_0;
  logic [DATA_W-1:0] req_src2_0;
  logic [DATA_W-1:0] req_src1_1;
  logic [DATA_W-1:0] req_src2_1;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_src1;
  logic [DATA_W-1:0] alu_src2;
  logic [DATA_W-1:0] alu_result;
  logic              busy;

  modport slave (
    input  flush, req_valid, req_op0, req_op1,
           req_src1_0, req_src2_0, req_src1_1, req_src2_1,
           resp_ready, alu_result,
    output req_ready, resp_valid, resp_data,
           alu_op, alu_src1, alu_src2, busy
  );

  modport master (
    output flush, req_valid, req_op0, req_op1,
           req_src1_0, req_src2_0, req_src1_1, req_src2_1,
           resp_ready, alu_result,
    input  req_ready, resp_valid, resp_data,
           alu_op, alu_src1, alu_src2, busy
  );
endinterface

// File: rtl/alu_share_arb.sv
// Two-port round-robin arbiter that time-shares one combinational ALU:
// accept (IDLE) -> drive ALU and capture result (EXEC) -> return result (RESP).
module alu_share_arb #(
  parameter int DATA_W = 64,
  parameter int OP_W   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_share_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              rr_ptr_r;
  logic              owner_r;
  logic [OP_W-1:0]   op_r;
  logic [DATA_W-1:0] src1_r;
  logic [DATA_W-1:0] src2_r;
  logic [DATA_W-1:0] res_r;

  logic              winner_s;
  logic              accept_s;
  logic              resp_fire_s;
  logic [1:0]        req_ready_s;
  logic [1:0]        resp_valid_s;
  logic              busy_s;

  // Grant winner: a lone requester wins, otherwise rr_ptr decides
  always_comb begin
    winner_s = 1'b0;
    case (bus.req_valid)
      2'b01:   winner_s = 1'b0;
      2'b10:   winner_s = 1'b1;
      2'b11:   winner_s = rr_ptr_r;
      default: winner_s = 1'b0;
    endcase
  end

  // rst_n gating keeps req_ready low while reset is asserted
  assign accept_s    = (state_r == IDLE) && !bus.flush && (|bus.req_valid) && rst_n;
  assign resp_fire_s = (state_r == RESP) && bus.resp_ready[owner_r];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush returns to IDLE from anywhere
  always_comb begin
    state_nxt_s = state_r;
    if (bus.flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = accept_s ? EXEC : IDLE;
        EXEC:    state_nxt_s = RESP;
        RESP:    state_nxt_s = resp_fire_s ? IDLE : RESP;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Output decode from state and owner
  always_comb begin
    req_ready_s  = 2'b00;
    resp_valid_s = 2'b00;
    busy_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          req_ready_s = {winner_s, ~winner_s};
        end else begin
          req_ready_s = 2'b00;
        end
      end
      EXEC: begin
        busy_s = 1'b1;
      end
      RESP: begin
        busy_s       = 1'b1;
        resp_valid_s = {owner_r, ~owner_r};
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Operand/owner capture on accept; rr_ptr points at the loser, untouched by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= {OP_W{1'b0}};
      src1_r   <= {DATA_W{1'b0}};
      src2_r   <= {DATA_W{1'b0}};
      owner_r  <= 1'b0;
      rr_ptr_r <= 1'b0;
    end else if (accept_s) begin
      op_r     <= winner_s ? bus.req_op0 ^ bus.req_op0 ^ bus.req_op1 : bus.req_op0;
      src1_r   <= winner_s ? bus.req_src1_1 : bus.req_src1_0;
      src2_r   <= winner_s ? bus.req_src2_1 : bus.req_src2_0;
      owner_r  <= winner_s;
      rr_ptr_r <= ~winner_s;
    end
  end

  // Result capture from the shared ALU during EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r <= {DATA_W{1'b0}};
    end else if (state_r == EXEC) begin
      res_r <= bus.alu_result;
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = resp_valid_s;
  assign bus.resp_data  = res_r;
  assign bus.alu_op     = op_r;
  assign bus.alu_src1   = src1_r;
  assign bus.alu_src2   = src2_r;
  assign bus.busy       = busy_s;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed-vector bench for alu_share_arb with a reference ALU and a
// response scoreboard popped by an independent monitor.
module tb_alu_share_arb;

  localparam int DATA_W = 64;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [OP_W-1:0] ALU_SLL  = 5'd2;
  localparam logic [OP_W-1:0] ALU_XOR  = 5'd3;
  localparam logic [OP_W-1:0] ALU_OR   = 5'd4;
  localparam logic [OP_W-1:0] ALU_ADDW = 5'd5;

  typedef struct {
    logic [1:0]        port;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [31:0] addw_s;

  alu_share_arb_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  alu_share_arb #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU
  assign addw_s = bus.alu_src1[31:0] + bus.alu_src2[31:0];
  always_comb begin
    bus.alu_result = 64'd0;
    case (bus.alu_op)
      ALU_ADD:  bus.alu_result = bus.alu_src1 + bus.alu_src2;
      ALU_SUB:  bus.alu_result = bus.alu_src1 - bus.alu_src2;
      ALU_SLL:  bus.alu_result = bus.alu_src1 << bus.alu_src2[5:0];
      ALU_XOR:  bus.alu_result = bus.alu_src1 ^ bus.alu_src2;
      ALU_OR:   bus.alu_result = bus.alu_src1 | bus.alu_src2;
      ALU_ADDW: bus.alu_result = {{32{addw_s[31]}}, addw_s};
      default:  bus.alu_result = 64'd0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] port, input logic [63:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: pop and compare on every response handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ((bus.resp_valid & bus.resp_ready) != 2'b00)) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'(bus.resp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_port", 64'(bus.resp_valid), 64'(e.port));
        check("resp_data", bus.resp_data, e.data);
      end
    end
  end

  task automatic set_req(input bit port, input logic [OP_W-1:0] op,
                         input logic [63:0] a, input logic [63:0] b);
    if (port) begin
      bus.req_op1    = op;
      bus.req_src1_1 = a;
      bus.req_src2_1 = b;
    end else begin
      bus.req_op0    = op;
      bus.req_src1_0 = a;
      bus.req_src2_0 = b;
    end
  endtask

  // Raise valid on one port, wait for the grant, then drop valid after the handshake edge
  task automatic issue(input bit port, input logic [OP_W-1:0] op,
                       input logic [63:0] a, input logic [63:0] b,
                       input bit do_push, input logic [63:0] exp);
    bit found = 1'b0;
    set_req(port, op, a, b);
    bus.req_valid[port] = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.req_ready[port]) found = 1'b1;
    end
    check("grant_seen", 64'(found), 64'd1);
    if (found && do_push) push_exp(port ? 2'b10 : 2'b01, exp);
    @(posedge clk);
    #1;
    bus.req_valid[port] = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int c = 0; c < 30 && !idle; c++) begin
      @(negedge clk);
      if (!bus.busy) idle = 1'b1;
    end
    check("idle_timeout", 64'(idle), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  cyc;
    int  last;
    bit  found;

    bus.flush      = 1'b0;
    bus.req_valid  = 2'b00;
    bus.resp_ready = 2'b11;
    set_req(1'b0, 5'd0, 64'd0, 64'd0);
    set_req(1'b1, 5'd0, 64'd0, 64'd0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_data", bus.resp_data, 64'd0);
    check("rst_alu_op", 64'(bus.alu_op), 64'd0);
    check("rst_alu_src1", bus.alu_src1, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request: Add(5,7) on port 0, response two cycles after the grant
    issue(1'b0, ALU_ADD, 64'd5, 64'd7, 1'b1, 64'd12);
    @(negedge clk);
    check("single_busy_exec", 64'(bus.busy), 64'd1);
    check("single_no_resp_exec", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    check("single_resp_valid", 64'(bus.resp_valid), 64'd1);
    check("single_resp_data", bus.resp_data, 64'd12);
    @(negedge clk);
    check("single_busy_after", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;

    // Addw opcode reaches the ALU unchanged
    issue(1'b0, ALU_ADDW, 64'h0000_0000_7FFF_FFFF, 64'd1, 1'b1, 64'hFFFF_FFFF_8000_0000);
    @(negedge clk);
    check("addw_alu_op", 64'(bus.alu_op), 64'(ALU_ADDW));
    wait_idle();

    // Wide data: Sub(0,1) on port 1
    issue(1'b1, ALU_SUB, 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle();

    // Contention: grants alternate 0,1,0,1 at the 3-cycle issue interval
    set_req(1'b0, ALU_SUB, 64'd10, 64'd3);
    set_req(1'b1, ALU_XOR, 64'hF0, 64'h0F);
    bus.req_valid = 2'b11;
    cyc  = 0;
    last = 0;
    for (int g = 0; g < 4; g++) begin
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        @(negedge clk);
        cyc++;
        if (bus.req_ready != 2'b00) found = 1'b1;
      end
      check("contention_grant", 64'(bus.req_ready), (g % 2 == 1) ? 64'd2 : 64'd1);
      if (g > 0) check("issue_interval", 64'(cyc - last), 64'd3);
      last = cyc;
      if (g % 2 == 1) push_exp(2'b10, 64'hFF);
      else            push_exp(2'b01, 64'd7);
      @(posedge clk);
    end
    #1 bus.req_valid = 2'b00;
    wait_idle();

    // Back-pressure: Sll(1,4) on port 1 stalled 5 cycles while port 0 waits
    bus.resp_ready = 2'b00;
    issue(1'b1, ALU_SLL, 64'd1, 64'd4, 1'b1, 64'd16);
    set_req(1'b0, ALU_ADD, 64'd2, 64'd3);
    bus.req_valid = 2'b01;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 bus.resp_ready = {1'b0, c[0]};
      @(negedge clk);
      check("bp_resp_valid", 64'(bus.resp_valid), 64'd2);
      check("bp_resp_data", bus.resp_data, 64'd16);
      check("bp_req_ready", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk);
    #1 bus.resp_ready = 2'b11;
    @(negedge clk);
    check("bp_release_no_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    check("bp_next_grant", 64'(bus.req_ready), 64'd1);
    if (bus.req_ready == 2'b01) push_exp(2'b01, 64'd5);
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    wait_idle();

    // Flush in EXEC drops the operation
    issue(1'b0, ALU_OR, 64'h3, 64'hC, 1'b0, 64'd0);
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_busy_exec", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy_after", 64'(bus.busy), 64'd0);
    check("flush_no_resp", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    check("flush_no_resp_later", 64'(bus.resp_valid), 64'd0);
    @(posedge clk);
    #1;
    issue(1'b1, ALU_ADD, 64'd100, 64'd23, 1'b1, 64'd123);
    wait_idle();

    // Async reset while port 0 result is pending; rr_ptr would favour port 1 otherwise
    bus.resp_ready = 2'b00;
    issue(1'b0, ALU_ADD, 64'd40, 64'd2, 1'b0, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("prerst_resp_valid", 64'(bus.resp_valid), 64'd1);
    set_req(1'b0, ALU_XOR, 64'hAA, 64'h55);
    set_req(1'b1, ALU_ADD, 64'd1, 64'd1);
    bus.req_valid = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    check("arst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("arst_resp_data", bus.resp_data, 64'd0);
    check("arst_alu_op", 64'(bus.alu_op), 64'd0);
    check("arst_alu_src1", bus.alu_src1, 64'd0);
    check("arst_alu_src2", bus.alu_src2, 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.resp_ready = 2'b11;
    @(negedge clk);
    check("postrst_grant", 64'(bus.req_ready), 64'd1);
    if (bus.req_ready == 2'b01) push_exp(2'b01, 64'hFF);
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    wait_idle();

    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter and sequencer that shares a single combinational ALU instance between two requesters: port 0 (EXU) and port 1 (auxiliary unit, e.g. AGU/CSR). It accepts one operation at a time over valid/ready, picks round-robin on contention, and registers operands into the shared ALU's `operator_1`/`operator_2`/`alu_op` inputs. It captures `alu_result` and returns it to the winning port over a valid/ready response channel. The block sits between the decode/issue logic and the ALU in the npc core.

## Interface
- `DATA_W`, default 64: operand/result width; matches the ALU immediate width.
- `OP_W`, default 5: ALU opcode width; matches the ALU op encoding width.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush` input 1: synchronous abort of the in-flight operation.
- `req_valid[1:0]` input 2: request valid, one bit per port.
- `req_ready[1:0]` output 2: request accepted when `valid & ready`.
- `req_op0`, `req_op1` input OP_W each: ALU opcode per port.
- `req_src1_0`, `req_src2_0`, `req_src1_1`, `req_src2_1` input DATA_W each: operands per port.
- `resp_valid[1:0]` output 2: result valid, one-hot to the owning port.
- `resp_ready[1:0]` input 2: port consumes result.
- `resp_data` output DATA_W: result, shared by both ports; qualified by `resp_valid`.
- `alu_op` output OP_W: to the shared ALU.
- `alu_src1`, `alu_src2` output DATA_W: to the shared ALU.
- `alu_result` input DATA_W: from the shared ALU, combinational.
- `busy` output 1: high in any state except IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `req_ready` is asserted only to the grant winner.
  - Grant rule: if exactly one `req_valid` is high, that port wins. If both are high, the port selected by `rr_ptr` wins.
  - On handshake: latch op/src1/src2 and owner id into registers, set `rr_ptr` to the non-winning port, go to EXEC.
- EXEC, exactly one cycle:
  - `alu_op`/`alu_src*` are driven from the latched registers. They are held at these registers in all states; zero after reset.
  - `alu_result` is registered into `res_q`; go to RESP.
- RESP:
  - `resp_valid[owner]` = 1 and `resp_data` = `res_q`, both held stable until `resp_ready[owner]`.
  - On handshake, go to IDLE.
  - `resp_ready` of the non-owner port is ignored.
- `req_ready` is 0 in EXEC and RESP. Requests stay pending; requesters must hold `valid` and payload stable until accepted.
- `flush`:
  - In any state, go to IDLE next cycle and drop the operation; no `resp_valid` is produced.
  - `flush` in IDLE blocks a same-cycle handshake (`req_ready` = 0).
  - `rr_ptr` is unchanged by flush.
- `rr_ptr` resets to port 0 priority.
- Width rules: the ALU is purely combinational; the block applies no truncation or extension. Results pass through bit-exact.

## Timing
- Reset values: state IDLE, `req_ready` = 2'b00 until the first cycle after reset release evaluates grant, `resp_valid` = 2'b00, `resp_data` = 0, `alu_op`/`alu_src1`/`alu_src2` = 0, `busy` = 0, `rr_ptr` = 0.
- `req_ready` is combinational from state, `req_valid`, `rr_ptr`, and `flush`. Reset deassertion mid-operation discards everything.
- Latency: request handshake in cycle N; `resp_valid` high in cycle N+2. Minimum issue interval is 3 cycles (N, N+1, N+2 with immediate `resp_ready`; next accept in N+3).
- Response back-pressure: a stalled `resp_ready` holds RESP indefinitely. `resp_data` must not change while stalled.
- Simultaneous `resp_ready` handshake and new `req_valid` in RESP: the new request is accepted in the following IDLE cycle, not in the same cycle.

## Test plan
- Single request: port 0 valid, op = AluAdd, src1 = 5, src2 = 7 -> `req_ready[0]` in cycle 0, `resp_valid` = 2'b01 with `resp_data` = 12 in cycle 2.
- Contention fairness: both ports continuously valid with Sub(10,3) on port 0 and Xor(0xF0,0x0F) on port 1 -> grants alternate 0,1,0,1; responses 7, 0xFF, 7, 0xFF.
- Back-pressure: AluSll(1,4) on port 1 with `resp_ready[1]` low 5 cycles -> `resp_data` = 16 stable, `resp_valid` = 2'b10 held for all 5 cycles; `req_ready` stays 0; `resp_ready[0]` pulses are ignored.
- Flush in EXEC: accept port 0 AluOr, assert `flush` the next cycle -> no `resp_valid`; `busy` = 0 the cycle after; a subsequent port 1 request is granted normally.
- Async reset mid-RESP: drop `rst_n` while `resp_valid` = 2'b01 -> all outputs are 0 immediately; after release, the first contention is granted to port 0.
- Wide data: AluSub(0, 1) with DATA_W = 64 -> `resp_data` = 0xFFFF_FFFF_FFFF_FFFF; AluAddw is passed through unchanged in `alu_op`.
